sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 20, SRAM word address width.
REQ-002 Parameter: DATA_W, default 16, SRAM data width.
REQ-003 Parameter: WAIT_CYCLES, default 2, access-strobe length in clocks; legal range 1..15.
REQ-004 clk  in  1  single clock; all state rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  processor access request; level, held until cpu_ack.
REQ-007 cpu_we  in  1  1 = write, 0 = read.
REQ-008 cpu_addr  in  ADDR_W  processor word address.
REQ-009 cpu_wdata  in  DATA_W  processor write data.
REQ-010 cpu_rdata  out  DATA_W  processor read data.
REQ-011 cpu_ack  out  1  one-cycle completion pulse.
REQ-012 uart_req, uart_we, uart_addr, uart_wdata, uart_rdata, uart_ack: same directions, widths and meanings for the UART loader port.
REQ-013 sram_addr  out  ADDR_W  SRAM address pins.
REQ-014 sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes.
REQ-015 sram_dq_out  out  DATA_W  write data toward the pad tristate.
REQ-016 sram_dq_oe  out  1  1 = drive the pad with sram_dq_out.
REQ-017 sram_dq_in  in  DATA_W  data from the pad.

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS, DONE; the FSM leaves IDLE only when at least one req is high.
REQ-019 Arbitration in IDLE: if only one req is high, that port wins; if both are high, the port not served last wins; last_grant resets to UART, so CPU wins the first tie.
REQ-020 IDLE->SETUP: latch grant, we, addr and wdata into internal registers; requester inputs are not sampled after this edge.
REQ-021 SETUP, 1 cycle: sram_ce_n=0, sram_addr valid; sram_oe_n=1, sram_we_n=1; sram_dq_oe=1 if write.
REQ-022 ACCESS, WAIT_CYCLES cycles counted by a 4-bit down-counter: read holds sram_oe_n=0; write holds sram_we_n=0 and sram_dq_oe=1; sram_ce_n=0, sram_ub_n=0, sram_lb_n=0.
REQ-023 Read data: on the final ACCESS edge, capture sram_dq_in into the granted port's rdata register; rdata holds until that port's next read completes.
REQ-024 DONE, 1 cycle: all strobes high, sram_dq_oe=0 for bus turnaround; granted port's ack=1; next state IDLE unconditionally.
REQ-025 Latency: req high in IDLE cycle k -> ack in cycle k+WAIT_CYCLES+2; back-to-back period WAIT_CYCLES+3 cycles.
REQ-026 cpu_ack and uart_ack are never high in the same cycle; ack never asserts without a preceding grant.
REQ-027 Requester dropping req mid-transaction: transaction completes and ack still pulses; the requester ignores the pulse.
REQ-028 sram_ce_n, oe_n and we_n are registered outputs and glitch-free; oe_n and we_n are never low in the same cycle.
REQ-029 sram_addr and sram_dq_out hold the latched values from SETUP through DONE.

Reset
REQ-030 rst_n low forces immediately: state IDLE; all sram_*_n = 1; sram_dq_oe=0; sram_addr=0; sram_dq_out=0; both rdata=0; both ack=0; last_grant=UART.
REQ-031 Reset mid-transaction aborts it with no ack; after release the FSM starts in IDLE.

Configuration
REQ-032 Macro SRAM_ARB_BYTE_EN defined: adds ports cpu_be[1:0] and uart_be[1:0], latched in IDLE->SETUP. During write ACCESS, sram_ub_n = ~be[1] and sram_lb_n = ~be[0]. Reads always enable both lanes.
REQ-033 SRAM_ARB_BYTE_EN undefined: be ports absent; sram_ub_n and sram_lb_n are low throughout SETUP/ACCESS for every access.

Structure
REQ-034 Package sram_arb_pkg holds the state enum, the port-id enum (PORT_CPU, PORT_UART) and WAIT_CYCLES bounds.
REQ-035 Sub-module sram_arb_rr: 2-input round-robin arbiter (reqs, last_grant -> grant); the FSM and datapath stay in sram_arbiter.

Verification
REQ-036 CPU write addr=0x00010, data=0xA5C3, WAIT_CYCLES=2 -> we_n low exactly 2 cycles; dq_oe high SETUP..ACCESS; cpu_ack 4 cycles after req.
REQ-037 CPU read 0x00010 with model returning 0xA5C3 -> cpu_rdata=0xA5C3 in the ack cycle; oe_n low 2 cycles; dq_oe=0 throughout.
REQ-038 Both req high continuously from reset -> grant order CPU, UART, CPU, UART; ack spacing 5 cycles; acks never overlap.
REQ-039 rst_n pulled low in the second ACCESS cycle of a write -> all strobes high and dq_oe=0 that cycle; no ack; next request completes normally.
REQ-040 Byte-enable build: UART write be=2'b10 data=0x12FF -> ub_n=0, lb_n=1 during ACCESS; model updates only the upper byte.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM states,
// port ids and access-strobe length bounds.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    PORT_CPU  = 1'b0,
    PORT_UART = 1'b1
  } port_t;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;

  // Down-counter load value; out-of-range lengths are clamped.
  function automatic logic [3:0] wait_load(input int w);
    int c;
    c = w;
    if (c < WAIT_MIN) c = WAIT_MIN;
    if (c > WAIT_MAX) c = WAIT_MAX;
    return 4'(c - 1);
  endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Two-input round-robin arbiter.
// Ports: cpu_req, uart_req, last_grant in; grant out.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic  cpu_req,
  input  logic  uart_req,
  input  port_t last_grant,
  output port_t grant
);

  always_comb begin
    grant = last_grant;
    unique case (1'b1)
      cpu_req & ~uart_req: grant = PORT_CPU;
      uart_req & ~cpu_req: grant = PORT_UART;
      cpu_req & uart_req:
        grant = (last_grant == PORT_CPU) ? PORT_UART
                                         : PORT_CPU;
      default: grant = last_grant;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (CPU, UART loader) asynchronous SRAM arbiter with
// registered strobes. Ports: cpu_*/uart_* request ports with
// one-cycle ack, sram_* pad-side pins. Optional macro
// SRAM_ARB_BYTE_EN adds cpu_be/uart_be write byte enables.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
`ifdef SRAM_ARB_BYTE_EN
  input  logic [1:0]        cpu_be,
  input  logic [1:0]        uart_be,
`endif
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  output logic [DATA_W-1:0] uart_rdata,
  output logic              uart_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in
);

  localparam logic [3:0] WLOAD = wait_load(WAIT_CYCLES);

  state_t state, nstate;
  port_t  grant, grant_q, last_grant;
  logic [3:0] cnt;
  logic       we_q, we_nx;
  logic       start, last;
  logic       ce_d, oe_d, we_d, ub_d, lb_d, dqoe_d;
  logic       cack_d, uack_d;
  logic [1:0] lane_n;

  sram_arb_rr u_rr (
    .cpu_req    (cpu_req),
    .uart_req   (uart_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign start = (state == IDLE) && (nstate == SETUP);
  assign last  = (state == ACCESS) && (cnt == 4'd0);

  // Outputs are registered from the next state, so the
  // attribute of the transaction must be seen one edge early.
  assign we_nx = (state == IDLE)
    ? ((grant == PORT_CPU) ? cpu_we : uart_we)
    : we_q;

`ifdef SRAM_ARB_BYTE_EN
  logic [1:0] be_q, be_nx;
  assign be_nx = (state == IDLE)
    ? ((grant == PORT_CPU) ? cpu_be : uart_be)
    : be_q;
  assign lane_n = we_nx ? ~be_nx : 2'b00;
`else
  assign lane_n = 2'b00;
`endif

  always_comb begin
    nstate = state;
    ce_d   = 1'b1;
    oe_d   = 1'b1;
    we_d   = 1'b1;
    ub_d   = 1'b1;
    lb_d   = 1'b1;
    dqoe_d = 1'b0;
    cack_d = 1'b0;
    uack_d = 1'b0;
    unique case (state)
      IDLE:
        if (cpu_req | uart_req) nstate = SETUP;
      SETUP:  nstate = ACCESS;
      ACCESS:
        if (cnt == 4'd0) nstate = DONE;
      DONE:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
    unique case (nstate)
      SETUP: begin
        ce_d         = 1'b0;
        {ub_d, lb_d} = lane_n;
        dqoe_d       = we_nx;
      end
      ACCESS: begin
        ce_d         = 1'b0;
        {ub_d, lb_d} = lane_n;
        dqoe_d       = we_nx;
        oe_d         = we_nx;
        we_d         = ~we_nx;
      end
      DONE: begin
        cack_d = (grant_q == PORT_CPU);
        uack_d = (grant_q == PORT_UART);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
      cpu_ack    <= 1'b0;
      uart_ack   <= 1'b0;
    end else begin
      state      <= nstate;
      sram_ce_n  <= ce_d;
      sram_oe_n  <= oe_d;
      sram_we_n  <= we_d;
      sram_ub_n  <= ub_d;
      sram_lb_n  <= lb_d;
      sram_dq_oe <= dqoe_d;
      cpu_ack    <= cack_d;
      uart_ack   <= uack_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= PORT_UART;
      last_grant  <= PORT_UART;
      we_q        <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
`ifdef SRAM_ARB_BYTE_EN
      be_q        <= 2'b11;
`endif
    end else if (start) begin
      grant_q    <= grant;
      last_grant <= grant;
      we_q       <= we_nx;
      if (grant == PORT_CPU) begin
        sram_addr   <= cpu_addr;
        sram_dq_out <= cpu_wdata;
      end else begin
        sram_addr   <= uart_addr;
        sram_dq_out <= uart_wdata;
      end
`ifdef SRAM_ARB_BYTE_EN
      be_q <= be_nx;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      cpu_rdata  <= '0;
      uart_rdata <= '0;
    end else begin
      if (state == SETUP)
        cnt <= WLOAD;
      else if (state == ACCESS && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (last && !we_q) begin
        if (grant_q == PORT_CPU) cpu_rdata  <= sram_dq_in;
        else                     uart_rdata <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a 256-word SRAM model.
// Build with SRAM_ARB_BYTE_EN to exercise byte enables.
module tb_sram_arbiter;

  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cpu_req, cpu_we, uart_req, uart_we;
  logic [19:0] cpu_addr, uart_addr, sram_addr;
  logic [15:0] cpu_wdata, uart_wdata;
  logic [15:0] cpu_rdata, uart_rdata;
  logic        cpu_ack, uart_ack;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic        sram_ub_n, sram_lb_n, sram_dq_oe;
  logic [15:0] sram_dq_out, sram_dq_in;
`ifdef SRAM_ARB_BYTE_EN
  logic [1:0]  cpu_be, uart_be;
`endif

  sram_arbiter #(
    .ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
`ifdef SRAM_ARB_BYTE_EN
    .cpu_be(cpu_be), .uart_be(uart_be),
`endif
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .uart_req(uart_req), .uart_we(uart_we),
    .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_rdata(uart_rdata), .uart_ack(uart_ack),
    .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in)
  );

  logic [15:0] mem [0:255];
  assign sram_dq_in = mem[sram_addr[7:0]];

  always @(posedge clk)
    if (rst_n && !sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n)
        mem[sram_addr[7:0]][7:0] <= sram_dq_out[7:0];
      if (!sram_ub_n)
        mem[sram_addr[7:0]][15:8] <= sram_dq_out[15:8];
    end

  int passed = 0;
  int total  = 0;
  logic [15:0] exp_cpu_rd  = '0;
  logic [15:0] exp_uart_rd = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h",
                  nm, act, exp);
  endtask

  typedef struct {
    bit          uart;
    bit          we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rd;
  } vec_t;

  task automatic drive(input vec_t v);
    if (v.uart) begin
      uart_req = 1'b1; uart_we = v.we;
      uart_addr = v.addr; uart_wdata = v.wdata;
`ifdef SRAM_ARB_BYTE_EN
      uart_be = v.be;
`endif
    end else begin
      cpu_req = 1'b1; cpu_we = v.we;
      cpu_addr = v.addr; cpu_wdata = v.wdata;
`ifdef SRAM_ARB_BYTE_EN
      cpu_be = v.be;
`endif
    end
  endtask

  task automatic run_txn(input vec_t v, input string tg);
    int n, wel, oel, dqo, bad, ubl, lbl;
    bit got;
    logic [15:0] cr, ur;
    logic [3:0] dn;
    n = 0; wel = 0; oel = 0; dqo = 0;
    bad = 0; ubl = 0; lbl = 0; got = 0;
    cr = '0; ur = '0; dn = '0;
    @(negedge clk);
    drive(v);
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (!sram_we_n) wel++;
      if (!sram_oe_n) oel++;
      if (sram_dq_oe) dqo++;
      if (!sram_we_n && !sram_oe_n) bad++;
      if (cpu_ack && uart_ack) bad++;
      if (v.uart ? cpu_ack : uart_ack) bad++;
      if (!sram_oe_n || !sram_we_n) begin
        if (!sram_ub_n) ubl++;
        if (!sram_lb_n) lbl++;
        if (sram_addr !== v.addr) bad++;
        if (v.we && sram_dq_out !== v.wdata) bad++;
      end
      if (v.uart ? uart_ack : cpu_ack) begin
        got = 1;
        cr = cpu_rdata; ur = uart_rdata;
        dn = {sram_ce_n, sram_oe_n,
              sram_we_n, sram_dq_oe};
      end
    end
    cpu_req = 1'b0; uart_req = 1'b0;
    if (!v.we) begin
      if (v.uart) exp_uart_rd = v.exp_rd;
      else        exp_cpu_rd  = v.exp_rd;
    end
    chk({tg, " ack"}, 32'(got), 1);
    chk({tg, " latency"}, n, W + 2);
    chk({tg, " we_n low"}, wel, v.we ? W : 0);
    chk({tg, " oe_n low"}, oel, v.we ? 0 : W);
    chk({tg, " dq_oe"}, dqo, v.we ? W + 1 : 0);
    chk({tg, " ub_n low"}, ubl,
        (!v.we || v.be[1]) ? W : 0);
    chk({tg, " lb_n low"}, lbl,
        (!v.we || v.be[0]) ? W : 0);
    chk({tg, " protocol"}, bad, 0);
    chk({tg, " done strobes"}, 32'(dn), 32'hE);
    chk({tg, " cpu_rdata"}, 32'(cr), 32'(exp_cpu_rd));
    chk({tg, " uart_rdata"}, 32'(ur), 32'(exp_uart_rd));
  endtask

  vec_t vq[$];

  initial begin
    int ackn, cyc, ov, seen;
    int ord[4];
    int tms[4];
    vec_t va;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    cpu_we = 0; uart_we = 0;
    cpu_addr = '0; uart_addr = 20'h00020;
    cpu_wdata = '0; uart_wdata = '0;
`ifdef SRAM_ARB_BYTE_EN
    cpu_be = 2'b11; uart_be = 2'b11;
`endif
    // Both ports request reads through reset.
    cpu_req = 1'b1; uart_req = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst strobes",
        {sram_ce_n, sram_oe_n, sram_we_n,
         sram_ub_n, sram_lb_n}, 32'h1F);
    chk("rst dq_oe", sram_dq_oe, 0);
    chk("rst addr", sram_addr, 0);
    chk("rst dq_out", sram_dq_out, 0);
    chk("rst rdata", {cpu_rdata, uart_rdata}, 0);
    chk("rst ack", {cpu_ack, uart_ack}, 0);

    for (int i = 0; i < 4; i++) begin
      ord[i] = 9; tms[i] = 0;
    end
    ackn = 0; cyc = 0; ov = 0;
    rst_n = 1'b1;
    while (ackn < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cpu_ack && uart_ack) ov++;
      if (cpu_ack || uart_ack) begin
        ord[ackn] = uart_ack ? 1 : 0;
        tms[ackn] = cyc;
        ackn++;
      end
    end
    cpu_req = 1'b0; uart_req = 1'b0;
    chk("tie acks", ackn, 4);
    chk("tie grant0", ord[0], 0);
    chk("tie grant1", ord[1], 1);
    chk("tie grant2", ord[2], 0);
    chk("tie grant3", ord[3], 1);
    chk("tie first", tms[0], W + 2);
    for (int i = 1; i < 4; i++)
      chk($sformatf("tie gap%0d", i),
          tms[i] - tms[i-1], W + 3);
    chk("tie overlap", ov, 0);

    vq.push_back('{0, 1, 20'h00010, 16'hA5C3, 2'b11, 0});
    vq.push_back('{0, 0, 20'h00010, 0, 2'b11, 16'hA5C3});
    vq.push_back('{1, 1, 20'h00020, 16'h1234, 2'b11, 0});
    vq.push_back('{1, 0, 20'h00020, 0, 2'b11, 16'h1234});
    vq.push_back('{0, 0, 20'h00020, 0, 2'b11, 16'h1234});
    vq.push_back('{1, 0, 20'h00010, 0, 2'b11, 16'hA5C3});
    vq.push_back('{0, 1, 20'h000FF, 16'hFFFF, 2'b11, 0});
    vq.push_back('{0, 0, 20'h000FF, 0, 2'b11, 16'hFFFF});
`ifdef SRAM_ARB_BYTE_EN
    vq.push_back('{1, 1, 20'h00030, 16'h0000, 2'b11, 0});
    vq.push_back('{1, 1, 20'h00030, 16'h12FF, 2'b10, 0});
    vq.push_back('{1, 0, 20'h00030, 0, 2'b11, 16'h1200});
    vq.push_back('{0, 1, 20'h00031, 16'h5A5A, 2'b01, 0});
    vq.push_back('{0, 0, 20'h00031, 0, 2'b11, 16'h005A});
`endif
    foreach (vq[i])
      run_txn(vq[i], $sformatf("v%0d", i));

    // Reset in the second ACCESS cycle of a write.
    va = '{0, 1, 20'h00050, 16'hDEAD, 2'b11, 0};
    @(negedge clk);
    drive(va);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort strobes",
        {sram_ce_n, sram_oe_n, sram_we_n,
         sram_ub_n, sram_lb_n}, 32'h1F);
    chk("abort dq_oe", sram_dq_oe, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_ack || uart_ack) seen++;
    end
    chk("abort no ack", seen, 0);
    exp_cpu_rd = '0; exp_uart_rd = '0;
    run_txn('{0, 1, 20'h00050, 16'hBEEF, 2'b11, 0}, "pa0");
    run_txn('{0, 0, 20'h00050, 0, 2'b11, 16'hBEEF}, "pa1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
